// File: rtl/button_pulse_gen.sv
// button_pulse_gen: synchronizes and debounces one raw push-button and emits
// single-cycle press / release / long-press / auto-repeat event pulses.
module button_pulse_gen #(
    parameter int DB_CYCLES     = 100_000,
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_1p,
    output logic release_1p,
    output logic long_1p,
    output logic repeat_1p,
    output logic held
);
    localparam int DBW = $clog2(DB_CYCLES) + 1;
    localparam int HW  = $clog2(LONG_CYCLES) + 1;
    localparam int RW  = $clog2(REPEAT_CYCLES) + 1;

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0]  REP_LAST  = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHORT, ST_LONG} state_t;

    logic           r_s1, r_s2, r_level;
    logic [DBW-1:0] r_db_cnt;
    state_t         r_state, w_state_nxt;
    logic [HW-1:0]  r_hold_cnt, w_hold_nxt;
    logic [RW-1:0]  r_rep_cnt, w_rep_nxt;
    logic           r_press, r_release, r_long, r_repeat, r_held;
    logic           w_press_nxt, w_release_nxt, w_long_nxt, w_repeat_nxt, w_held_nxt;
    logic           w_accept, w_rise, w_fall;

    // A level change is accepted on the edge where the mismatch run reaches DB_CYCLES.
    assign w_accept = (r_s2 != r_level) && (r_db_cnt == DB_LAST);
    assign w_rise   = w_accept && r_s2;
    assign w_fall   = w_accept && !r_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_level  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
            if (r_s2 == r_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_level  <= ~r_level;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DBW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rep_cnt  <= w_rep_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
            r_repeat   <= w_repeat_nxt;
            r_held     <= w_held_nxt;
        end
    end

    // An accepted fall is tested first so it always beats a terminal count.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_rep_nxt     = r_rep_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
        w_held_nxt    = r_held;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_SHORT;
                    w_press_nxt = 1'b1;
                    w_hold_nxt  = '0;
                end
            end
            ST_SHORT: begin
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_release_nxt = 1'b1;
                    w_hold_nxt    = '0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_LONG;
                    w_long_nxt  = 1'b1;
                    w_held_nxt  = 1'b1;
                    w_rep_nxt   = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + HW'(1);
                end
            end
            ST_LONG: begin
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_release_nxt = 1'b1;
                    w_held_nxt    = 1'b0;
                    w_hold_nxt    = '0;
                    w_rep_nxt     = '0;
                end else if (r_rep_cnt == REP_LAST) begin
                    w_repeat_nxt = REPEAT_EN;
                    w_rep_nxt    = '0;
                end else begin
                    w_rep_nxt = r_rep_cnt + RW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_held_nxt  = 1'b0;
            end
        endcase
    end

    assign btn_level  = r_level;
    assign press_1p   = r_press;
    assign release_1p = r_release;
    assign long_1p    = r_long;
    assign repeat_1p  = r_repeat;
    assign held       = r_held;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: an event-level model checked every cycle against
// a repeat-enabled and a repeat-disabled instance, plus directed literal checks.
module tb_button_pulse_gen;
    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic lvl_a, press_a, rel_a, long_a, rep_a, held_a;
    logic lvl_b, press_b, rel_b, long_b, rep_b, held_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    button_pulse_gen #(.DB_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(lvl_a), .press_1p(press_a),
        .release_1p(rel_a), .long_1p(long_a), .repeat_1p(rep_a), .held(held_a)
    );

    button_pulse_gen #(.DB_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(lvl_b), .press_1p(press_b),
        .release_1p(rel_b), .long_1p(long_b), .repeat_1p(rep_b), .held(held_b)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic quiet(input string nm, input int k);
        repeat (k) begin
            @(negedge clk);
            chk(nm, lvl_a | press_a | rel_a | long_a | rep_a | held_a, 1'b0);
        end
    endtask

    // Model: the level flips once the last DB raw samples, seen two edges late,
    // all disagree with it; events are timed arithmetically from the press edge.
    bit q[$];
    int m_n, m_pe, m_dt;
    bit m_lvl, m_flip;
    bit e_press, e_rel, e_long, e_rep, e_held;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q = {};
                for (int i = 0; i <= DB; i++) q.push_back(1'b0);
                m_n = 0; m_pe = 0; m_lvl = 1'b0;
                e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0; e_held = 1'b0;
            end else begin
                m_n++;
                m_flip = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (q[q.size()-2-j] == m_lvl) m_flip = 1'b0;
                e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
                if (m_flip) begin
                    m_lvl = !m_lvl;
                    if (m_lvl) begin
                        e_press = 1'b1;
                        m_pe = m_n;
                    end else begin
                        e_rel = 1'b1;
                    end
                end
                m_dt = m_n - m_pe;
                if (m_lvl && !m_flip) begin
                    e_long = (m_dt == LONG);
                    e_rep  = (m_dt > LONG) && ((m_dt - LONG) % REP == 0);
                end
                e_held = m_lvl && (m_dt >= LONG);
                q.push_back(btn_in);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("a.level", lvl_a, m_lvl);      chk("b.level", lvl_b, m_lvl);
            chk("a.press", press_a, e_press);  chk("b.press", press_b, e_press);
            chk("a.release", rel_a, e_rel);    chk("b.release", rel_b, e_rel);
            chk("a.long", long_a, e_long);     chk("b.long", long_b, e_long);
            chk("a.repeat", rep_a, e_rep);     chk("b.repeat", rep_b, 1'b0);
            chk("a.held", held_a, e_held);     chk("b.held", held_b, e_held);
        end
    end

    initial begin
        tick(3);
        chk("reset.level", lvl_a, 1'b0);
        chk("reset.press", press_a, 1'b0);
        chk("reset.held", held_a, 1'b0);
        rst = 1'b0;
        tick(3);

        // clean press: rise before edge 1, high through edge 10
        btn_in = 1'b1;
        tick(5); chk("clean.press_early", press_a, 1'b0);
        tick(1); chk("clean.press", press_a, 1'b1); chk("clean.level", lvl_a, 1'b1);
        tick(1); chk("clean.press_drop", press_a, 1'b0);
        tick(3); btn_in = 1'b0;
        tick(5); chk("clean.release_early", rel_a, 1'b0);
        tick(1); chk("clean.release", rel_a, 1'b1); chk("clean.level_low", lvl_a, 1'b0);
        tick(1); chk("clean.release_drop", rel_a, 1'b0);
        tick(10);

        // glitch rejection
        btn_in = 1'b1; quiet("glitch", 3);
        btn_in = 1'b0; quiet("glitch", 2);
        btn_in = 1'b1; quiet("glitch", 3);
        btn_in = 1'b0; quiet("glitch", 12);

        // long hold with auto-repeat; accepted fall lands at press+42
        btn_in = 1'b1;
        tick(6); chk("long.press", press_a, 1'b1);
        for (int k = 1; k <= 50; k++) begin
            tick(1);
            chk("long.long", long_a, k == 20);
            chk("long.held", held_a, (k >= 20) && (k < 42));
            chk("long.repeat", rep_a, (k == 25) || (k == 30) || (k == 35) || (k == 40));
            chk("long.release", rel_a, k == 42);
            chk("long.b_long", long_b, k == 20);
            if (k == 36) btn_in = 1'b0;
        end
        tick(5);

        // accepted fall coincides with the long terminal count
        btn_in = 1'b1;
        tick(6); chk("tc.press", press_a, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            chk("tc.long", long_a, 1'b0);
            chk("tc.held", held_a, 1'b0);
            chk("tc.release", rel_a, k == 20);
            if (k == 14) btn_in = 1'b0;
        end
        tick(5);

        // reset while in long-hold
        btn_in = 1'b1;
        tick(33); chk("rst.held_before", held_a, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst.held", held_a, 1'b0);
        chk("rst.level", lvl_a, 1'b0);
        chk("rst.release", rel_a, 1'b0);
        chk("rst.b_held", held_b, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(5); chk("rst.press_early", press_a, 1'b0);
        tick(1); chk("rst.press", press_a, 1'b1);
        btn_in = 1'b0;
        tick(12); chk("rst.level_final", lvl_a, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
